cpu_ctrl: RTL
=============

Name: cpu_ctrl

Overview:
Multicycle control unit that drives the 8-bit `alu` core. It fetches 8-bit instructions from a synchronous memory and decodes them into `aluOp`, register-file selects and write strobes. It captures the ALU flags (Z, C, N) into a status register and resolves conditional jumps from those flags. It sits between program memory, the 4x8 register file and `alu`, and produces the `aluOp` encoding that `alu` consumes.

Parameters:
- PC_W, 8, program counter and memory address width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  PC_W  program memory read address.
- mem_rdata  in  8  memory read data, valid one cycle after mem_addr.
- aluOp  out  4  ALU operation select.
- alu_Z  in  1  zero flag from ALU.
- alu_C  in  1  carry flag from ALU.
- alu_N  in  1  negative flag from ALU.
- rf_ra  out  2  register-file read port A select (rd).
- rf_rb  out  2  register-file read port B select (rs).
- rf_wa  out  2  register-file write address.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_wsel  out  1  write-data mux: 0 = ALU result, 1 = imm.
- imm  out  8  immediate operand latch.
- pc  out  PC_W  current program counter.
- flags  out  3  status register {Z,C,N}.
- halted  out  1  high while in HALT.

Behaviour:
- Instruction format: ir[7:4] opcode, ir[3:2] rd, ir[1:0] rs.
- ALU opcodes pass through unchanged to `aluOp`: 0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR. Each computes rd <= f(rd, rs).
- Control opcodes: 0000 NOP, 0100 LDI (rd <= next byte), 0101 JMP, 0110 JZ, 0111 JC, 1000 JN (target = next byte), 1111 HLT. All other opcodes execute as NOP.
- Reset values: pc=RESET_PC, ir=0, imm=0, flags=0, aluOp=0000, rf_we=0, rf_wsel=0, rf_ra/rb/wa=0, halted=0, state=FETCH.
- rst overrides everything in any state, including mid-instruction. Any pending write is dropped.
- FSM states and transitions:
  - FETCH: mem_addr=pc. Next state LOAD_IR.
  - LOAD_IR: ir<=mem_rdata; pc<=pc+1. Next state DECODE.
  - DECODE, dispatch on opcode:
    - ALU op -> EXEC.
    - LDI/JMP/Jcc -> OPND, with mem_addr=pc.
    - HLT -> HALT.
    - NOP/undefined -> FETCH.
  - EXEC: aluOp=opcode; rf_ra=rd; rf_rb=rs; rf_wa=rd; rf_wsel=0; rf_we=1. At the clock edge, flags<={alu_Z,alu_C,alu_N} for all five ALU ops. Next state FETCH.
  - OPND: imm<=mem_rdata; pc<=pc+1.
    - JMP, or Jcc with its flag set: pc<=mem_rdata instead. The jump target overrides the increment.
    - LDI -> WB. All others -> FETCH.
  - WB: rf_wa=rd; rf_wsel=1; rf_we=1. Next state FETCH.
  - HALT: halted=1; no memory or register activity; leave only via rst.
- Outside EXEC, aluOp=0000. rf_we is high only in EXEC and WB.
- Cycle counts: ALU op 4, NOP/undefined 3, HLT 3 to reach HALT, jump 4 (taken or not), LDI 5.
- Jcc tests the flags register as it stands at OPND, i.e. the result of the most recent ALU op. LDI and jumps never modify flags.
- PC is modulo 2^PC_W: 0xFF+1 -> 0x00. An operand fetched at 0xFF reads from 0xFF and continues at 0x00.
- mem_addr is held at pc in all non-fetch states to avoid X on the bus.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants (OP_NOP, OP_ADD, OP_SUB, OP_NOR, OP_LDI, OP_JMP, OP_JZ, OP_JC, OP_JN, OP_SHL, OP_SHR, OP_HLT);
  - FSM state encoding;
  - flag bit indices (FLG_Z=2, FLG_C=1, FLG_N=0).
- `alu` and the test bench import the same opcode constants.
- One combinational sub-module, `cpu_decode`: ir -> {is_alu, is_opnd, is_ldi, is_jmp, cond_sel, is_hlt}. The FSM and datapath registers stay in cpu_ctrl.

Test Plan:
- Reset behaviour: assert rst for 2 cycles mid-EXEC of ADD -> next cycle pc=00, rf_we=0, flags=000, mem_addr=00; first fetch follows.
- ADD sequence: memory 00:41 01:0A 02:44 03:05 04:11 (LDI r0,10; LDI r1,5; ADD r0,r1) -> one rf_we pulse per LDI with rf_wsel=1 and imm=0A, then 05; at cycle 14 aluOp=0001, rf_ra=0, rf_rb=1, rf_wa=0, rf_we=1; with model ALU result=15, flags=000.
- SUB and conditional jump: SUB 20-30 with alu_C=1, alu_N=1 driven, then JN 0x20 -> flags=011, pc=20 after OPND. Repeat with JZ instead -> not taken, pc increments by 2.
- SHL/SHR passthrough: opcodes B0 and C0 -> aluOp=1011, then 1100, each asserted for exactly one cycle in EXEC.
- PC wrap: program counter at 0xFE holding LDI r2 (0x48) -> operand read from 0xFF, pc becomes 0x00.
- Illegal opcode and HLT: opcode 9x -> 3-cycle NOP, no rf_we. Opcode F0 -> halted=1; pc and mem_addr stay frozen for 20 cycles; rst clears halted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, FSM-state and flag definitions for the 8-bit CPU control path.
// Imported by the controller, its decoder, the ALU and the bench.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_NOR = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JN  = 4'h8;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_N = 0;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_LOAD_IR = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_OPND    = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // Which status flag a conditional jump tests; COND_NONE for everything else.
  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_Z    = 2'd1,
    COND_C    = 2'd2,
    COND_N    = 2'd3
  } cond_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
           (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode classifier: splits an opcode into the dispatch classes
// the controller FSM branches on. Undefined opcodes leave every class low.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_is_alu,
  output logic       o_is_opnd,
  output logic       o_is_ldi,
  output logic       o_is_jmp,
  output logic [1:0] o_cond_sel,
  output logic       o_is_hlt
);

  always_comb begin
    o_is_alu   = is_alu_op(i_opcode);
    o_is_opnd  = 1'b0;
    o_is_ldi   = 1'b0;
    o_is_jmp   = 1'b0;
    o_cond_sel = COND_NONE;
    o_is_hlt   = 1'b0;
    case (i_opcode)
      OP_LDI: begin
        o_is_opnd = 1'b1;
        o_is_ldi  = 1'b1;
      end
      OP_JMP: begin
        o_is_opnd = 1'b1;
        o_is_jmp  = 1'b1;
      end
      OP_JZ: begin
        o_is_opnd  = 1'b1;
        o_cond_sel = COND_Z;
      end
      OP_JC: begin
        o_is_opnd  = 1'b1;
        o_cond_sel = COND_C;
      end
      OP_JN: begin
        o_is_opnd  = 1'b1;
        o_cond_sel = COND_N;
      end
      OP_HLT: o_is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multicycle fetch/decode/execute controller driving the 8-bit ALU and 4x8 register file.
// ALU op 4 cycles, NOP 3, jump 4, LDI 5; HLT parks the FSM until reset.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  output logic [3:0]      aluOp,
  input  logic            alu_Z,
  input  logic            alu_C,
  input  logic            alu_N,
  output logic [1:0]      rf_ra,
  output logic [1:0]      rf_rb,
  output logic [1:0]      rf_wa,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      flags,
  output logic            halted
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [7:0]      r_imm;
  logic [2:0]      r_flags;
  logic [3:0]      r_alu_op;
  logic [1:0]      r_rf_ra;
  logic [1:0]      r_rf_rb;
  logic [1:0]      r_rf_wa;
  logic            r_rf_we;
  logic            r_rf_wsel;
  logic            r_halted;

  logic [3:0]      w_opcode;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs;
  logic            w_is_alu;
  logic            w_is_opnd;
  logic            w_is_ldi;
  logic            w_is_jmp;
  logic [1:0]      w_cond_sel;
  logic            w_is_hlt;
  logic            w_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;

  assign w_opcode = r_ir[7:4];
  assign w_rd     = r_ir[3:2];
  assign w_rs     = r_ir[1:0];
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_target = PC_W'(mem_rdata);

  cpu_decode u_decode (
    .i_opcode   (w_opcode),
    .o_is_alu   (w_is_alu),
    .o_is_opnd  (w_is_opnd),
    .o_is_ldi   (w_is_ldi),
    .o_is_jmp   (w_is_jmp),
    .o_cond_sel (w_cond_sel),
    .o_is_hlt   (w_is_hlt)
  );

  // Conditional jumps look at the stored flags, i.e. the last ALU result.
  always_comb begin
    w_taken = w_is_jmp;
    case (w_cond_sel)
      COND_Z:  w_taken = r_flags[FLG_Z];
      COND_C:  w_taken = r_flags[FLG_C];
      COND_N:  w_taken = r_flags[FLG_N];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_imm     <= '0;
      r_flags   <= '0;
      r_alu_op  <= OP_NOP;
      r_rf_ra   <= '0;
      r_rf_rb   <= '0;
      r_rf_wa   <= '0;
      r_rf_we   <= 1'b0;
      r_rf_wsel <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      // Strobes are registered: they are set on the edge that enters EXEC/WB
      // and cleared on every other edge, so each lasts exactly one state.
      r_alu_op  <= OP_NOP;
      r_rf_we   <= 1'b0;
      r_rf_wsel <= 1'b0;
      case (r_state)
        S_FETCH: r_state <= S_LOAD_IR;
        S_LOAD_IR: begin
          r_ir    <= mem_rdata;
          r_pc    <= w_pc_inc;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_is_alu) begin
            r_alu_op <= w_opcode;
            r_rf_ra  <= w_rd;
            r_rf_rb  <= w_rs;
            r_rf_wa  <= w_rd;
            r_rf_we  <= 1'b1;
            r_state  <= S_EXEC;
          end else if (w_is_opnd) begin
            r_state <= S_OPND;
          end else if (w_is_hlt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC: begin
          r_flags[FLG_Z] <= alu_Z;
          r_flags[FLG_C] <= alu_C;
          r_flags[FLG_N] <= alu_N;
          r_state        <= S_FETCH;
        end
        S_OPND: begin
          r_imm <= mem_rdata;
          r_pc  <= w_taken ? w_target : w_pc_inc;
          if (w_is_ldi) begin
            r_rf_wa   <= w_rd;
            r_rf_wsel <= 1'b1;
            r_rf_we   <= 1'b1;
            r_state   <= S_WB;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Gating with rst drops a write strobe that is already on the bus when reset hits.
  assign rf_we    = r_rf_we & ~rst;
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign aluOp    = r_alu_op;
  assign rf_ra    = r_rf_ra;
  assign rf_rb    = r_rf_rb;
  assign rf_wa    = r_rf_wa;
  assign rf_wsel  = r_rf_wsel;
  assign imm      = r_imm;
  assign flags    = r_flags;
  assign halted   = r_halted;

endmodule
